// File: rtl/layer2_classifier.sv
// layer2_classifier: second dense layer. Streams W2 weights and ReLU'd layer-1
// activations over a 16-bit Avalon-MM master, accumulates 10 Q8.8 dot products,
// writes saturated logits back to memory and reports the argmax digit.
module layer2_classifier #(
    parameter int unsigned N_IN     = 200,
    parameter int unsigned N_OUT    = 10,
    parameter int unsigned L1_BASE  = 400_000,
    parameter int unsigned W2_BASE  = 160_000,
    parameter int unsigned OUT_BASE = 450_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [15:0] readdata,
    output logic        chipselect,
    output logic [1:0]  byteenable,
    output logic        read_n,
    output logic        write_n,
    output logic [31:0] address,
    output logic [15:0] writedata,
    input  logic        ready,
    output logic        done,
    output logic [3:0]  digit,
    output logic [31:0] toHexLed
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 16;
    localparam int unsigned IW   = 8;
    localparam int unsigned JW   = 4;
    localparam int unsigned ACCW = 40;
    localparam int unsigned PW   = 32;

    localparam logic [IW-1:0]        I_LAST    = IW'(N_IN - 1);
    localparam logic [JW-1:0]        J_LAST    = JW'(N_OUT - 1);
    localparam logic signed [DW-1:0] BEST_INIT = 16'sh8000;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RW_REQ  = 4'd1,
        RW_WAIT = 4'd2,
        RA_REQ  = 4'd3,
        RA_WAIT = 4'd4,
        MAC     = 4'd5,
        NEXT_I  = 4'd6,
        WR_REQ  = 4'd7,
        NEXT_J  = 4'd8,
        DONE    = 4'd9
    } state_t;

    state_t                 state, state_nxt;
    logic                   read_n_nxt, write_n_nxt, done_nxt;
    logic [AW-1:0]          address_nxt;
    logic [DW-1:0]          writedata_nxt;
    logic [JW-1:0]          digit_nxt;
    logic [IW-1:0]          i, i_nxt;
    logic [JW-1:0]          j, j_nxt;
    logic signed [ACCW-1:0] acc, acc_nxt;
    logic signed [DW-1:0]   best, best_nxt;
    logic [DW-1:0]          last_logit, last_logit_nxt;
    logic signed [DW-1:0]   w_val, w_val_nxt;
    logic signed [DW-1:0]   a_val, a_val_nxt;

    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_sh;
    logic [DW-1:0]          logit;

    assign chipselect = 1'b1;
    assign byteenable = 2'b11;

    // Byte address of weight (jj, ii) in the row-major W2 matrix.
    function automatic logic [AW-1:0] weight_addr(input logic [JW-1:0] jj, input logic [IW-1:0] ii);
        return AW'(W2_BASE + 2 * (AW'(jj) * N_IN + AW'(ii)));
    endfunction

    // Byte address of layer-1 activation ii.
    function automatic logic [AW-1:0] act_addr(input logic [IW-1:0] ii);
        return AW'(L1_BASE + 2 * AW'(ii));
    endfunction

    // Byte address of output logit jj.
    function automatic logic [AW-1:0] out_addr(input logic [JW-1:0] jj);
        return AW'(OUT_BASE + 2 * AW'(jj));
    endfunction

    assign prod     = w_val * a_val;
    assign prod_ext = $signed({{(ACCW - PW){prod[PW-1]}}, prod});

    // Q8.8 logit from the accumulator, saturated to 16 bits.
    always_comb begin
        acc_sh = acc >>> 8;
        if (acc_sh > 40'sd32767) begin
            logit = 16'h7FFF;
        end else if (acc_sh < -40'sd32768) begin
            logit = 16'h8000;
        end else begin
            logit = acc_sh[DW-1:0];
        end
    end

    // Next-state, bus strobes and datapath updates.
    always_comb begin
        state_nxt      = state;
        read_n_nxt     = read_n;
        write_n_nxt    = write_n;
        address_nxt    = address;
        writedata_nxt  = writedata;
        done_nxt       = done;
        digit_nxt      = digit;
        i_nxt          = i;
        j_nxt          = j;
        acc_nxt        = acc;
        best_nxt       = best;
        last_logit_nxt = last_logit;
        w_val_nxt      = w_val;
        a_val_nxt      = a_val;

        case (state)
            IDLE: begin
                acc_nxt   = '0;
                i_nxt     = '0;
                j_nxt     = '0;
                best_nxt  = BEST_INIT;
                digit_nxt = '0;
                done_nxt  = 1'b0;
                if (ready) begin
                    state_nxt   = RW_REQ;
                    read_n_nxt  = 1'b0;
                    address_nxt = weight_addr('0, '0);
                end
            end
            RW_REQ: begin
                if (!waitrequest) begin
                    read_n_nxt = 1'b1;
                    state_nxt  = RW_WAIT;
                end
            end
            RW_WAIT: begin
                if (readdatavalid) begin
                    w_val_nxt   = $signed(readdata);
                    read_n_nxt  = 1'b0;
                    address_nxt = act_addr(i);
                    state_nxt   = RA_REQ;
                end
            end
            RA_REQ: begin
                if (!waitrequest) begin
                    read_n_nxt = 1'b1;
                    state_nxt  = RA_WAIT;
                end
            end
            RA_WAIT: begin
                if (readdatavalid) begin
                    a_val_nxt = readdata[DW-1] ? '0 : $signed(readdata);
                    state_nxt = MAC;
                end
            end
            MAC: begin
                acc_nxt   = acc + prod_ext;
                state_nxt = NEXT_I;
            end
            NEXT_I: begin
                if (i == I_LAST) begin
                    i_nxt         = '0;
                    write_n_nxt   = 1'b0;
                    address_nxt   = out_addr(j);
                    writedata_nxt = logit;
                    state_nxt     = WR_REQ;
                end else begin
                    i_nxt       = i + IW'(1);
                    read_n_nxt  = 1'b0;
                    address_nxt = weight_addr(j, i + IW'(1));
                    state_nxt   = RW_REQ;
                end
            end
            WR_REQ: begin
                if (!waitrequest) begin
                    write_n_nxt    = 1'b1;
                    last_logit_nxt = writedata;
                    if ($signed(writedata) > best) begin
                        best_nxt  = $signed(writedata);
                        digit_nxt = j;
                    end
                    state_nxt = NEXT_J;
                end
            end
            NEXT_J: begin
                acc_nxt = '0;
                if (j == J_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    j_nxt       = j + JW'(1);
                    read_n_nxt  = 1'b0;
                    address_nxt = weight_addr(j + JW'(1), '0);
                    state_nxt   = RW_REQ;
                end
            end
            DONE: begin
                if (!ready) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, outputs and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            read_n     <= 1'b1;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            done       <= 1'b0;
            digit      <= '0;
            i          <= '0;
            j          <= '0;
            acc        <= '0;
            best       <= BEST_INIT;
            last_logit <= '0;
            w_val      <= '0;
            a_val      <= '0;
            toHexLed   <= '0;
        end else begin
            state      <= state_nxt;
            read_n     <= read_n_nxt;
            write_n    <= write_n_nxt;
            address    <= address_nxt;
            writedata  <= writedata_nxt;
            done       <= done_nxt;
            digit      <= digit_nxt;
            i          <= i_nxt;
            j          <= j_nxt;
            acc        <= acc_nxt;
            best       <= best_nxt;
            last_logit <= last_logit_nxt;
            w_val      <= w_val_nxt;
            a_val      <= a_val_nxt;
            toHexLed   <= {digit_nxt, j_nxt, 8'(state_nxt), last_logit_nxt};
        end
    end

endmodule
